// File: rtl/poker_pkg.sv
// Shared types and defaults for the poker player-input receiver.
// FSM state encoding, default field widths and the action code table.
package poker_pkg;

  localparam int DEFAULT_ACTION_W = 3;
  localparam int DEFAULT_MONEY_W  = 8;
  localparam int TIMEOUT_CNT_W    = 16;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REQUEST   = 2'd1,
    ACCEPT    = 2'd2,
    WAIT_DROP = 2'd3
  } rx_state_t;

  // Action codes carried in each player's ACTION_W slice (default width)
  typedef enum logic [2:0] {
    ACT_FOLD   = 3'd0,
    ACT_CHECK  = 3'd1,
    ACT_CALL   = 3'd2,
    ACT_RAISE  = 3'd3,
    ACT_ALL_IN = 3'd4
  } action_t;

endpackage

// File: rtl/multi_player_input_rx_if.sv
// Bus bundle between the game controller and the per-player input channels.
// The slave modport is the receiver's view; master is the environment's view.
interface multi_player_input_rx_if
  import poker_pkg::*;
#(
  parameter int NUM_PLAYERS = 4,
  parameter int ACTION_W    = DEFAULT_ACTION_W,
  parameter int MONEY_W     = DEFAULT_MONEY_W
);
  localparam int SEL_W = $clog2(NUM_PLAYERS);

  logic                            get_player_input;
  logic [SEL_W-1:0]                player_sel;
  logic [NUM_PLAYERS*ACTION_W-1:0] players_input;
  logic [NUM_PLAYERS*MONEY_W-1:0]  players_money;
  logic [NUM_PLAYERS-1:0]          valid_input;
  logic [NUM_PLAYERS-1:0]          request_input;
  logic [NUM_PLAYERS-1:0]          accepted_input;
  logic [ACTION_W-1:0]             accepted_players_input;
  logic [MONEY_W-1:0]              accepted_players_money;
  logic [SEL_W-1:0]                accepted_player_id;
  logic                            done;
  logic                            timed_out;

  modport slave (
    input  get_player_input, player_sel, players_input, players_money, valid_input,
    output request_input, accepted_input, accepted_players_input,
           accepted_players_money, accepted_player_id, done, timed_out
  );

  modport master (
    output get_player_input, player_sel, players_input, players_money, valid_input,
    input  request_input, accepted_input, accepted_players_input,
           accepted_players_money, accepted_player_id, done, timed_out
  );

endinterface

// File: rtl/input_timeout_ctr.sv
// REQUEST dwell counter: cleared on entry, counts each REQUEST cycle and
// flags the last permitted cycle so the FSM can abandon the request.
module input_timeout_ctr
  import poker_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic expire
);
  logic [TIMEOUT_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // cnt_q counts completed REQUEST cycles, so TIMEOUT_CYC-1 marks the final one
  assign expire = en && (cnt_q == TIMEOUT_CNT_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/multi_player_input_rx.sv
// Requests one action/bet from a selected player and captures it on valid.
// Optional REQUEST timeout is enabled by defining INPUT_TIMEOUT_EN.
module multi_player_input_rx
  import poker_pkg::*;
#(
  parameter int NUM_PLAYERS = 4,
  parameter int ACTION_W    = DEFAULT_ACTION_W,
  parameter int MONEY_W     = DEFAULT_MONEY_W,
  parameter int TIMEOUT_CYC = 255
) (
  input logic                    clk,
  input logic                    rst,
  multi_player_input_rx_if.slave bus
);
  localparam int SEL_W = $clog2(NUM_PLAYERS);
  localparam logic [SEL_W:0] NUM_P = (SEL_W + 1)'(NUM_PLAYERS);

  if (NUM_PLAYERS < 2 || NUM_PLAYERS > 8 || TIMEOUT_CYC < 2 || TIMEOUT_CYC > 65535) begin : g_bad_param
    $error("multi_player_input_rx: parameter out of range");
  end

  rx_state_t           state_q, state_d;
  logic [SEL_W-1:0]    cur_sel_q, cur_sel_d;
  logic [ACTION_W-1:0] acc_action_q, acc_action_d;
  logic [MONEY_W-1:0]  acc_money_q, acc_money_d;
  logic [SEL_W-1:0]    acc_id_q, acc_id_d;
  logic                req_entry;
  logic                sel_valid;
  logic                timeout_hit;
  logic                tmo_expire;

  assign sel_valid = bus.valid_input[cur_sel_q];

  always_comb begin
    state_d      = state_q;
    cur_sel_d    = cur_sel_q;
    acc_action_d = acc_action_q;
    acc_money_d  = acc_money_q;
    acc_id_d     = acc_id_q;
    req_entry    = 1'b0;
    timeout_hit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.get_player_input && ({1'b0, bus.player_sel} < NUM_P)) begin
          req_entry = 1'b1;
          cur_sel_d = bus.player_sel;
          state_d   = REQUEST;
        end
      end
      REQUEST: begin
        // Capture takes priority over an expiring timeout on the same edge
        if (sel_valid) begin
          acc_action_d = bus.players_input[int'(cur_sel_q)*ACTION_W +: ACTION_W];
          acc_money_d  = bus.players_money[int'(cur_sel_q)*MONEY_W +: MONEY_W];
          acc_id_d     = cur_sel_q;
          state_d      = ACCEPT;
        end else if (tmo_expire) begin
          timeout_hit = 1'b1;
          state_d     = IDLE;
        end
      end
      ACCEPT:    state_d = sel_valid ? WAIT_DROP : IDLE;
      WAIT_DROP: if (!sel_valid) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cur_sel_q    <= '0;
      acc_action_q <= '0;
      acc_money_q  <= '0;
      acc_id_q     <= '0;
    end else begin
      state_q      <= state_d;
      cur_sel_q    <= cur_sel_d;
      acc_action_q <= acc_action_d;
      acc_money_q  <= acc_money_d;
      acc_id_q     <= acc_id_d;
    end
  end

`ifdef INPUT_TIMEOUT_EN
  logic timed_out_q, timed_out_d;

  input_timeout_ctr #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timeout_ctr (
    .clk    (clk),
    .rst    (rst),
    .clear  (req_entry),
    .en     (state_q == REQUEST),
    .expire (tmo_expire)
  );

  always_comb begin
    timed_out_d = timeout_hit;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timed_out_q <= 1'b0;
    end else begin
      timed_out_q <= timed_out_d;
    end
  end

  assign bus.timed_out = timed_out_q;
`else
  assign tmo_expire    = 1'b0;
  assign bus.timed_out = 1'b0;
`endif

  for (genvar gi = 0; gi < NUM_PLAYERS; gi++) begin : g_onehot
    assign bus.request_input[gi]  = (state_q == REQUEST) && (cur_sel_q == SEL_W'(gi));
    assign bus.accepted_input[gi] = ((state_q == ACCEPT) || (state_q == WAIT_DROP)) &&
                                    (cur_sel_q == SEL_W'(gi));
  end

  assign bus.done                   = (state_q == ACCEPT);
  assign bus.accepted_players_input = acc_action_q;
  assign bus.accepted_players_money = acc_money_q;
  assign bus.accepted_player_id     = acc_id_q;

  // Only consumed by the timeout counter when it is built in
  logic unused_ok;
  assign unused_ok = req_entry | timeout_hit;

endmodule
